// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Asynchronous serial transmitter. One start bit, 5 to 8 data
//               bits sent LSB first, optional parity bit (odd, even, forced 0
//               or forced 1), then one or two stop bits. Words are taken over
//               a valid/ready handshake and the serial line is driven from a
//               flop, so it only changes on bit boundaries.
//
// Ports       :
//   clk_i            in   1   clock, all state updates on the rising edge
//   rst_n_i          in   1   asynchronous active-low reset
//   cfg_en_i         in   1   block enable; low aborts any frame, forces IDLE
//   cfg_div_i        in  16   bit period minus one in clk_i cycles (live)
//   cfg_parity_en_i  in   1   insert a parity bit after the data bits
//   cfg_parity_sel_i in   2   00 odd, 01 even, 10 forced 0, 11 forced 1
//   cfg_bits_i       in   2   data bits: 00=5, 01=6, 10=7, 11=8
//   cfg_stop_bits_i  in   1   0 = one stop bit, 1 = two stop bits
//   tx_data_i        in   8   word to send, unused upper bits ignored
//   tx_valid_i       in   1   word available
//   tx_ready_o       out  1   word accepted when valid and ready are both high
//   tx_o             out  1   serial line, idle high
//   busy_o           out  1   high whenever a frame is in progress
//
// Build option:
//   UART_TX_STOP2_EN  when defined, cfg_stop_bits_i=1 gives two stop-bit
//                     periods; when undefined the port is kept but ignored
//                     and exactly one stop bit is always sent.
//
// Revision    : 1.0  initial release
// ============================================================================

module uart_tx (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_parity_sel_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and frame registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_baud_cnt;     // cycles spent in the current bit
    logic [2:0]  r_bit_idx;      // index of the data bit on the line
    logic        r_stop_phase;   // second stop period in progress
    logic        r_tx;

    // Per-frame copy of the framing configuration, taken at acceptance so a
    // configuration change mid-frame only affects the following frame.
    logic [7:0]  r_data;
    logic [1:0]  r_bits;
    logic        r_parity_en;
    logic [1:0]  r_parity_sel;
    logic        r_stop2;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_bit_done;
    logic [2:0]  w_last_idx;
    logic [2:0]  w_next_idx;
    logic [7:0]  w_data_mask;
    logic        w_data_xor;
    logic        w_parity_bit;
    logic        w_two_stop;

    // The divider is sampled live. Comparing with >= instead of == keeps a
    // bit from stretching to a full 16-bit wrap if the divider is lowered
    // below the running count in the middle of a bit.
    assign w_bit_done = (r_baud_cnt >= cfg_div_i);

    // Data width is 5 + r_bits, so the last index is 4 + r_bits.
    assign w_last_idx = 3'd4 + {1'b0, r_bits};
    assign w_next_idx = r_bit_idx + 3'd1;

    // Only the bits actually transmitted contribute to the parity.
    always_comb begin
        w_data_mask = 8'hFF;
        case (r_bits)
            2'b00:   w_data_mask = 8'h1F;
            2'b01:   w_data_mask = 8'h3F;
            2'b10:   w_data_mask = 8'h7F;
            default: w_data_mask = 8'hFF;
        endcase
    end

    assign w_data_xor = ^(r_data & w_data_mask);

    always_comb begin
        w_parity_bit = 1'b0;
        case (r_parity_sel)
            2'b00:   w_parity_bit = ~w_data_xor;   // odd
            2'b01:   w_parity_bit = w_data_xor;    // even
            2'b10:   w_parity_bit = 1'b0;          // forced 0
            default: w_parity_bit = 1'b1;          // forced 1
        endcase
    end

`ifdef UART_TX_STOP2_EN
    assign w_two_stop = r_stop2;
`else
    // Stop-bit selection compiled out: the latched flag is kept so the port
    // stays connected, but it never extends the stop period.
    assign w_two_stop = r_stop2 & 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Frame sequencer. tx_o is registered and is always loaded with the value
    // of the bit being entered, so it only toggles at bit boundaries.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_baud_cnt   <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_stop_phase <= 1'b0;
            r_tx         <= 1'b1;
            r_data       <= 8'd0;
            r_bits       <= 2'd0;
            r_parity_en  <= 1'b0;
            r_parity_sel <= 2'd0;
            r_stop2      <= 1'b0;
        end else if (!cfg_en_i) begin
            // Disable aborts silently: back to an idle line with clean counters.
            r_state      <= IDLE;
            r_baud_cnt   <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_stop_phase <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx         <= 1'b1;
                    r_baud_cnt   <= 16'd0;
                    r_bit_idx    <= 3'd0;
                    r_stop_phase <= 1'b0;
                    // tx_ready_o is high here (enabled and IDLE).
                    if (tx_valid_i) begin
                        r_data       <= tx_data_i;
                        r_bits       <= cfg_bits_i;
                        r_parity_en  <= cfg_parity_en_i;
                        r_parity_sel <= cfg_parity_sel_i;
                        r_stop2      <= cfg_stop_bits_i;
                        r_state      <= START_BIT;
                        r_tx         <= 1'b0;
                    end
                end

                START_BIT: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= DATA;
                        r_tx       <= r_data[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        if (r_bit_idx == w_last_idx) begin
                            if (r_parity_en) begin
                                r_state <= PARITY;
                                r_tx    <= w_parity_bit;
                            end else begin
                                r_state      <= STOP_BIT;
                                r_stop_phase <= 1'b0;
                                r_tx         <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_data[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                PARITY: begin
                    if (w_bit_done) begin
                        r_baud_cnt   <= 16'd0;
                        r_state      <= STOP_BIT;
                        r_stop_phase <= 1'b0;
                        r_tx         <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                STOP_BIT: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        if (w_two_stop && !r_stop_phase) begin
                            r_stop_phase <= 1'b1;
                        end else begin
                            r_stop_phase <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_baud_cnt   <= 16'd0;
                    r_bit_idx    <= 3'd0;
                    r_stop_phase <= 1'b0;
                    r_tx         <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_ready_o = cfg_en_i & (r_state == IDLE);
    assign busy_o     = (r_state != IDLE);
    assign tx_o       = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx. Each scenario task
//               drives a frame and compares tx_o / busy_o / tx_ready_o on
//               every cycle against hand-written expected bit sequences.
//               Outputs are sampled on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================

module tb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        cfg_parity_en;
    logic [1:0]  cfg_parity_sel;
    logic [1:0]  cfg_bits;
    logic        cfg_stop_bits;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;

    int vectors;
    int miscompares;

    uart_tx dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cfg_en_i         (cfg_en),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_sel_i (cfg_parity_sel),
        .cfg_bits_i       (cfg_bits),
        .cfg_stop_bits_i  (cfg_stop_bits),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .tx_o             (tx),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: tx_o=%b busy_o=%b expected 1 0", tx, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: tx_o=%b busy_o=%b tx_ready_o=%b expected 1 0 1",
                     tx, busy, tx_ready);
        end
        cfg_en = 1'b0;
        #1;
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_follows_en: tx_ready_o=%b expected 0", tx_ready);
        end
        cfg_en = 1'b1;
        @(negedge clk);
    endtask

    // 8N1, div=3, 0xA5. Framing config is scrambled right after acceptance to
    // show the frame uses the copy taken at acceptance.
    task automatic test_basic_8n1();
        logic [9:0] exp;
        exp = 10'b1101001010;          // 0,1,0,1,0,0,1,0,1,1 on the line
        cfg_div = 16'd3; cfg_bits = 2'b11; cfg_parity_en = 1'b0;
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_bits = 2'b00; cfg_parity_en = 1'b1; tx_data = 8'h00;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (tx !== exp[b] || busy !== 1'b1 || tx_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_8n1 bit %0d cyc %0d: tx_o=%b busy_o=%b tx_ready_o=%b expected %b 1 0",
                             b, c, tx, busy, tx_ready, exp[b]);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_8n1 end: tx_o=%b busy_o=%b tx_ready_o=%b expected 1 0 1",
                     tx, busy, tx_ready);
        end
        cfg_bits = 2'b11; cfg_parity_en = 1'b0;
    endtask

    // div=0: 0x07 8 bits under all four parity modes, then 7-bit 0x81 even
    // (bit 7 must not enter the parity).
    task automatic test_parity();
        logic [3:0]  exp_par;
        logic [10:0] exp;
        logic [9:0]  exp7;
        exp_par = 4'b1010;             // sel 00->0, 01->1, 10->0, 11->1
        cfg_div = 16'd0; cfg_bits = 2'b11; cfg_parity_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cfg_parity_sel = 2'(s);
            exp = {1'b1, exp_par[s], 8'h07, 1'b0};
            tx_data = 8'h07; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            for (int b = 0; b < 11; b++) begin
                vectors++;
                if (tx !== exp[b] || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL parity sel %0d bit %0d: tx_o=%b busy_o=%b expected %b 1",
                             s, b, tx, busy, exp[b]);
                end
                @(negedge clk);
            end
            vectors++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                miscompares++;
                $display("FAIL parity sel %0d end: tx_o=%b busy_o=%b expected 1 0", s, tx, busy);
            end
        end
        cfg_bits = 2'b10; cfg_parity_sel = 2'b01;
        exp7 = {1'b1, 1'b1, 7'h01, 1'b0};
        tx_data = 8'h81; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            vectors++;
            if (tx !== exp7[b]) begin
                miscompares++;
                $display("FAIL parity_7bit bit %0d: tx_o=%b expected %b", b, tx, exp7[b]);
            end
            @(negedge clk);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_7bit end: busy_o=%b expected 0", busy);
        end
        cfg_parity_en = 1'b0; cfg_parity_sel = 2'b00; cfg_bits = 2'b11;
    endtask

    // div=1, 5 bits, 0xFF: start, five ones, stop -> 14 cycles.
    task automatic test_five_bits();
        logic [6:0] exp;
        exp = {1'b1, 5'h1F, 1'b0};
        cfg_div = 16'd1; cfg_bits = 2'b00; cfg_parity_en = 1'b0;
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (tx !== exp[b] || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL five_bits bit %0d cyc %0d: tx_o=%b busy_o=%b expected %b 1",
                             b, c, tx, busy, exp[b]);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL five_bits length: tx_o=%b busy_o=%b expected 1 0 after 14 cycles", tx, busy);
        end
        cfg_bits = 2'b11;
    endtask

    // tx_valid held high across two words, div=2.
    task automatic test_back_to_back();
        logic [9:0] exp1;
        logic [9:0] exp2;
        exp1 = {1'b1, 8'h11, 1'b0};
        exp2 = {1'b1, 8'h22, 1'b0};
        cfg_div = 16'd2; cfg_bits = 2'b11; cfg_parity_en = 1'b0;
        tx_data = 8'h11; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;               // valid stays high while busy
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (tx !== exp1[b] || tx_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b word1 bit %0d cyc %0d: tx_o=%b tx_ready_o=%b expected %b 0",
                             b, c, tx, tx_ready, exp1[b]);
                end
                @(negedge clk);
            end
        end
        // Single IDLE accept cycle between the frames.
        vectors++;
        if (busy !== 1'b0 || tx_ready !== 1'b1 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b gap: tx_o=%b busy_o=%b tx_ready_o=%b expected 1 0 1", tx, busy, tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (tx !== exp2[b] || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b word2 bit %0d cyc %0d: tx_o=%b busy_o=%b expected %b 1",
                             b, c, tx, busy, exp2[b]);
                end
                @(negedge clk);
            end
        end
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b no_duplicate cyc %0d: tx_o=%b busy_o=%b expected 1 0", c, tx, busy);
            end
            @(negedge clk);
        end
    endtask

    // Enable dropped during data bit 3, then 0x55 sent after re-enable.
    task automatic test_enable_abort();
        logic [9:0] exp;
        exp = {1'b1, 8'h55, 1'b0};
        cfg_div = 16'd1; cfg_bits = 2'b11; cfg_parity_en = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        // start + data bits 0..2 at 2 cycles each, then first cycle of bit 3
        repeat (8) @(negedge clk);
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort pre: tx_o=%b busy_o=%b expected 0 1", tx, busy);
        end
        cfg_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: tx_o=%b busy_o=%b tx_ready_o=%b expected 1 0 0", tx, busy, tx_ready);
        end
        @(negedge clk);
        cfg_en = 1'b1;
        #1;
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort reenable: tx_ready_o=%b expected 1", tx_ready);
        end
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 2; c++) begin
                vectors++;
                if (tx !== exp[b] || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort resend bit %0d cyc %0d: tx_o=%b busy_o=%b expected %b 1",
                             b, c, tx, busy, exp[b]);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort resend end: busy_o=%b expected 0", busy);
        end
    endtask

    // Asynchronous reset in the middle of a frame.
    task automatic test_reset_midframe();
        logic [9:0] exp;
        exp = {1'b1, 8'h3C, 1'b0};
        cfg_div = 16'd3; cfg_bits = 2'b11; cfg_parity_en = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe: tx_o=%b busy_o=%b expected 1 0", tx, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cfg_div = 16'd0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            vectors++;
            if (tx !== exp[b] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_restart bit %0d: tx_o=%b busy_o=%b expected %b 1", b, tx, busy, exp[b]);
            end
            @(negedge clk);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_restart end: busy_o=%b expected 0", busy);
        end
    endtask

    // cfg_stop_bits_i=1, div=3: 8 stop cycles with the option built in, else 4.
    task automatic test_stop_bits();
        int nstop;
`ifdef UART_TX_STOP2_EN
        nstop = 8;
`else
        nstop = 4;
`endif
        cfg_div = 16'd3; cfg_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        // start + 8 zero data bits = 36 low cycles
        for (int c = 0; c < 36; c++) begin
            vectors++;
            if (tx !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_bits low cyc %0d: tx_o=%b expected 0", c, tx);
            end
            @(negedge clk);
        end
        for (int c = 0; c < nstop; c++) begin
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stop_bits stop cyc %0d: tx_o=%b busy_o=%b expected 1 1", c, tx, busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_bits length: busy_o=%b expected 0 after %0d stop cycles", busy, nstop);
        end
        cfg_stop_bits = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; cfg_en = 1'b1; cfg_div = 16'd0;
        cfg_parity_en = 1'b0; cfg_parity_sel = 2'b00; cfg_bits = 2'b11;
        cfg_stop_bits = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

        test_reset();
        test_basic_8n1();
        test_parity();
        test_five_bits();
        test_back_to_back();
        test_enable_abort();
        test_reset_midframe();
        test_stop_bits();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
